decode_dispatch_ctrl: RTL and testbench
=======================================

Name: decode_dispatch_ctrl

Overview:
Decode-stage dispatch controller between fetch and the three issue paths. Buffers fetched instructions in a small FIFO and classifies the head entry by opcode group (integer/load/JALR, store/branch, upper-immediate/jump). Steers the head to the matching issue port with per-port valid/ready backpressure. Handles pipeline flush and undecodable opcodes.

Parameters:
DEPTH, 2, FIFO entries; power of two, >= 2
PC_W, 32, width of the carried program counter
CNT_W, 16, width of the dispatch statistics counter

Ports:
clk  input  1  clock; all logic on the rising edge
rst  input  1  synchronous reset, active-high
flush  input  1  discard all buffered and in-flight instructions
in_valid  input  1  fetch offers an instruction
in_ready  output  1  controller can accept (registered-state based)
in_instr  input  32  RISC-V instruction word
in_pc  input  PC_W  PC of in_instr
out_valid  output  3  one-hot issue request; [0]=group 01, [1]=group 10, [2]=group 11
out_ready  input  3  per-port issue acceptance
out_data  output  25  head instr[31:7]
out_opcode  output  7  head instr[6:0]
out_spec  output  1  group sub-specifier of head
out_pc  output  PC_W  PC of head
dispatch_count  output  CNT_W  number of dispatched instructions, wraps
drop_count  output  CNT_W  number of group-00 instructions discarded, wraps

Behaviour:
- Reset (rst=1 at a clock edge): FIFO empty, state RUN, dispatch_count=0, drop_count=0. While empty after reset: out_valid=000, in_ready=1. out_data, out_opcode, out_spec and out_pc are don't-care while out_valid=000.
- Group classification of the head opcode (combinational):
  - group 01: 0110011 (spec 0), 0010011, 0000011, 1100111 (spec 1)
  - group 10: 0100011 (spec 0), 1100011 (spec 1)
  - group 11: 1101111 (spec 0), 0110111, 0010111 (spec 1)
  - any other opcode: group 00
- Push: in_valid && in_ready && !flush writes to the tail. in_ready = (occupancy != DEPTH) && state==RUN. in_ready never depends on out_ready.
- Latency: a word accepted in cycle N is presented no earlier than cycle N+1. There is no combinational in->out path.
- Dispatch: out_valid[g] = head valid && group(head)==g && state==RUN && !flush. At most one bit is set.
- Pop: the head pops when out_valid[g] && out_ready[g]. On pop, dispatch_count increments by 1, modulo 2^CNT_W.
- Push and pop may occur in the same cycle. Occupancy is then unchanged and the pointers wrap modulo DEPTH.
- Full: in_ready=0, so a push on a full FIFO cannot occur.
- Empty: out_valid=000, and out_ready is ignored.
- flush=1 at an edge: occupancy becomes 0 and state becomes RUN. A concurrent push is discarded and no dispatch occurs. flush has priority over everything except rst.
- rst has priority over flush. Reset asserted mid-operation discards all contents immediately.
- Group-00 head (macro undefined): the entry is popped in the cycle it is at the head with out_valid=000, and drop_count increments. The next entry is presented in the following cycle. Handling follows FIFO order and allows no bypass.
- States: RUN and TRAP. TRAP is reachable only with the optional feature.

Optional Feature:
Macro DECODE_ILLEGAL_TRAP_EN.
- Defined:
  - Add output trap_valid (1), output trap_pc (PC_W) and input trap_ack (1).
  - A group-00 head moves RUN->TRAP at the next edge.
  - In TRAP: trap_valid=1, trap_pc=head PC, out_valid=000, in_ready=0.
  - trap_ack=1 in TRAP: FIFO clears, drop_count increments, state returns to RUN at that edge.
  - flush in TRAP: state returns to RUN and the FIFO clears, without incrementing drop_count.
  - Reset value: trap_valid=0.
- Undefined: the drop behaviour above applies, no trap ports exist, and the state is always RUN.

Test Plan:
1. Reset, then push 0x00A00093 (addi) at PC 0x100 with out_ready=111 -> cycle+1: out_valid=001, out_opcode=0010011, out_spec=1, out_pc=0x100; dispatch_count=1 after the pop.
2. out_ready=000, push sw 0x00112023 then jal 0x0000006F -> in_ready=0 after 2 pushes (DEPTH=2). out_valid holds 010 with out_spec=0. Raise out_ready[1] -> out_valid becomes 100 next cycle with out_spec=0.
3. Continuous streaming with out_ready=111 and alternating lui/beq/add -> one dispatch per cycle, FIFO order preserved, dispatch_count equals the push count; run past a pointer wrap.
4. Fill the FIFO, then assert flush with in_valid=1 -> next cycle out_valid=000, occupancy 0, in_ready=1; the flushed-cycle word never appears.
5. Push opcode 0x00000000, then add: macro undefined -> drop_count=1, add dispatches on out_valid[0] one cycle later. Macro defined -> trap_valid=1, trap_pc=PC of the zero word, in_ready=0; after trap_ack, FIFO is empty and state returns to RUN.
6. Assert rst mid-stream with 2 entries queued -> next cycle out_valid=000, both counters 0, in_ready=1.

Source files
------------

// File: rtl/decode_dispatch_ctrl.sv
// Decode-stage dispatch controller: buffers fetched words, classifies the head opcode
// and steers it to one of three issue ports. Optional trap path: DECODE_ILLEGAL_TRAP_EN.
module decode_dispatch_ctrl #(
    parameter int DEPTH = 2,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [PC_W-1:0]  in_pc,
    output logic [2:0]       out_valid,
    input  logic [2:0]       out_ready,
    output logic [24:0]      out_data,
    output logic [6:0]       out_opcode,
    output logic             out_spec,
    output logic [PC_W-1:0]  out_pc,
    output logic [CNT_W-1:0] dispatch_count,
    output logic [CNT_W-1:0] drop_count
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    output logic             trap_valid,
    output logic [PC_W-1:0]  trap_pc,
    input  logic             trap_ack
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_t;

    // Returns {group[1:0], spec} for an opcode; group 00 means undecodable.
    function automatic logic [2:0] classify(input logic [6:0] op);
        logic [2:0] res;
        case (op)
            7'b0110011:                         res = 3'b010;
            7'b0010011, 7'b0000011, 7'b1100111: res = 3'b011;
            7'b0100011:                         res = 3'b100;
            7'b1100011:                         res = 3'b101;
            7'b1101111:                         res = 3'b110;
            7'b0110111, 7'b0010111:             res = 3'b111;
            default:                            res = 3'b000;
        endcase
        return res;
    endfunction

    logic [31:0]      r_mem_instr [DEPTH];
    logic [PC_W-1:0]  r_mem_pc    [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    state_t           r_state;
    logic [CNT_W-1:0] r_dispatch_count;
    logic [CNT_W-1:0] r_drop_count;

    state_t           w_next_state;
    logic             w_empty;
    logic             w_full;
    logic [31:0]      w_head_instr;
    logic [PC_W-1:0]  w_head_pc;
    logic [2:0]       w_class;
    logic [1:0]       w_group;
    logic             w_in_ready;
    logic [2:0]       w_out_valid;
    logic             w_push;
    logic             w_dispatch;
    logic             w_drop_pop;
    logic             w_pop;
    logic             w_clear;
    logic             w_drop_inc;

    assign w_empty      = (r_count == {CW{1'b0}});
    assign w_full       = (r_count == CW'(DEPTH));
    assign w_head_instr = r_mem_instr[r_rd_ptr];
    assign w_head_pc    = r_mem_pc[r_rd_ptr];
    assign w_class      = classify(w_head_instr[6:0]);
    assign w_group      = w_class[2:1];

    // Next-state, issue steering and FIFO control decisions.
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 3'b000;
        w_dispatch   = 1'b0;
        w_drop_pop   = 1'b0;
        w_clear      = 1'b0;
        w_drop_inc   = 1'b0;

        if (r_state == ST_RUN) begin
            w_in_ready = !w_full;
        end else begin
            w_in_ready = 1'b0;
        end

        if (flush) begin
            w_next_state = ST_RUN;
            w_clear      = 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (!w_empty) begin
                        case (w_group)
                            2'b01:   w_out_valid = 3'b001;
                            2'b10:   w_out_valid = 3'b010;
                            2'b11:   w_out_valid = 3'b100;
                            default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                                w_next_state = ST_TRAP;
`else
                                w_drop_pop   = 1'b1;
                                w_drop_inc   = 1'b1;
`endif
                            end
                        endcase
                        w_dispatch = |(w_out_valid & out_ready);
                    end else begin
                        w_out_valid = 3'b000;
                    end
                end
                ST_TRAP: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                    if (trap_ack) begin
                        w_clear      = 1'b1;
                        w_drop_inc   = 1'b1;
                        w_next_state = ST_RUN;
                    end else begin
                        w_next_state = ST_TRAP;
                    end
`else
                    w_next_state = ST_RUN;
`endif
                end
                default: w_next_state = ST_RUN;
            endcase
        end
    end

    assign w_push = in_valid && w_in_ready && !flush;
    assign w_pop  = w_dispatch || w_drop_pop;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FIFO pointers and occupancy; a clear wins over any push or pop.
    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_rd_ptr <= {AW{1'b0}};
            r_wr_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Payload storage; contents are only meaningful under a valid occupancy.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_instr[r_wr_ptr] <= in_instr;
            r_mem_pc[r_wr_ptr]    <= in_pc;
        end
    end

    // Wrapping dispatch and drop statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dispatch_count <= {CNT_W{1'b0}};
            r_drop_count     <= {CNT_W{1'b0}};
        end else begin
            if (w_dispatch) begin
                r_dispatch_count <= r_dispatch_count + CNT_W'(1);
            end
            if (w_drop_inc) begin
                r_drop_count <= r_drop_count + CNT_W'(1);
            end
        end
    end

    assign in_ready       = w_in_ready;
    assign out_valid      = w_out_valid;
    assign out_data       = w_head_instr[31:7];
    assign out_opcode     = w_head_instr[6:0];
    assign out_spec       = w_class[0];
    assign out_pc         = w_head_pc;
    assign dispatch_count = r_dispatch_count;
    assign drop_count     = r_drop_count;

`ifdef DECODE_ILLEGAL_TRAP_EN
    assign trap_valid = (r_state == ST_TRAP);
    assign trap_pc    = w_head_pc;
`endif

endmodule

// File: tb/tb_decode_dispatch_ctrl.sv
// Randomized scoreboard bench for decode_dispatch_ctrl with a queue-based reference model.
module tb_decode_dispatch_ctrl;
    localparam int DEPTH = 2;
    localparam int PC_W  = 32;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst, flush, in_valid, in_ready, out_spec;
    logic [31:0]      in_instr;
    logic [PC_W-1:0]  in_pc, out_pc;
    logic [2:0]       out_valid, out_ready;
    logic [24:0]      out_data;
    logic [6:0]       out_opcode;
    logic [CNT_W-1:0] dispatch_count, drop_count;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic             trap_valid, trap_ack;
    logic [PC_W-1:0]  trap_pc;
`endif

    always #5 clk = ~clk;

    decode_dispatch_ctrl #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_opcode(out_opcode), .out_spec(out_spec), .out_pc(out_pc),
        .dispatch_count(dispatch_count), .drop_count(drop_count)
`ifdef DECODE_ILLEGAL_TRAP_EN
        , .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_ack(trap_ack)
`endif
    );

    // Opcode table: entries 0..8 are decodable, 9..11 are undecodable samples.
    localparam logic [6:0] OP_TAB [12] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63,
                                          7'h6f, 7'h37, 7'h17, 7'h00, 7'h7f, 7'h0f};
    localparam int GRP_TAB  [12] = '{1, 1, 1, 1, 2, 2, 3, 3, 3, 0, 0, 0};
    localparam int SPEC_TAB [12] = '{0, 1, 1, 1, 0, 1, 0, 1, 1, 0, 0, 0};

    typedef struct packed {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
    } entry_t;

    entry_t          mq[$];
    logic [CNT_W-1:0] exp_disp, exp_drop;
    bit              m_trap = 1'b0;
    bit              mon_en = 1'b0;
    int              n_cmp = 0;
    int              n_bad = 0;

    function automatic int grp_of(input logic [6:0] op);
        int g = 0;
        for (int i = 0; i < 12; i++) if (OP_TAB[i] == op) g = GRP_TAB[i];
        return g;
    endfunction

    function automatic int spec_of(input logic [6:0] op);
        int s = 0;
        for (int i = 0; i < 12; i++) if (OP_TAB[i] == op) s = SPEC_TAB[i];
        return s;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advances the instruction queue once per rising edge.
    always @(posedge clk) begin
        bit push_ok;
        int g;
        entry_t e;
        push_ok = in_valid && (mq.size() < DEPTH) && !m_trap && !flush;
        if (rst) begin
            mq.delete();
            exp_disp = '0;
            exp_drop = '0;
            m_trap   = 1'b0;
            mon_en   = 1'b1;
        end else if (flush) begin
            mq.delete();
            m_trap = 1'b0;
        end else begin
            if (m_trap) begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                if (trap_ack) begin
                    mq.delete();
                    exp_drop++;
                    m_trap = 1'b0;
                end
`endif
            end else if (mq.size() > 0) begin
                g = grp_of(mq[0].instr[6:0]);
                if (g == 0) begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                    m_trap = 1'b1;
`else
                    void'(mq.pop_front());
                    exp_drop++;
`endif
                end else if (out_ready[g-1]) begin
                    void'(mq.pop_front());
                    exp_disp++;
                end
            end
            if (push_ok) begin
                e.instr = in_instr;
                e.pc    = in_pc;
                mq.push_back(e);
            end
        end
    end

    // Monitor: compares presented outputs against the model head on the falling edge.
    always @(negedge clk) begin
        logic [2:0] exp_ov;
        int g;
        if (mon_en) begin
            exp_ov = 3'b000;
            if (!m_trap && mq.size() > 0 && !flush) begin
                g = grp_of(mq[0].instr[6:0]);
                if (g != 0) exp_ov = 3'b001 << (g - 1);
            end
            chk("in_ready", in_ready, (mq.size() < DEPTH) && !m_trap);
            chk("out_valid", out_valid, exp_ov);
            if (exp_ov != 3'b000 && out_valid == exp_ov) begin
                chk("out_instr", {out_data, out_opcode}, mq[0].instr);
                chk("out_pc", out_pc, mq[0].pc);
                chk("out_spec", out_spec, spec_of(mq[0].instr[6:0]));
            end
            chk("dispatch_count", dispatch_count, exp_disp);
            chk("drop_count", drop_count, exp_drop);
`ifdef DECODE_ILLEGAL_TRAP_EN
            chk("trap_valid", trap_valid, m_trap);
            if (m_trap) chk("trap_pc", trap_pc, mq[0].pc);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] ins, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0;
        out_ready = 3'b000;
`ifdef DECODE_ILLEGAL_TRAP_EN
        trap_ack = 1'b0;
`endif
        repeat (2) step();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", out_valid, 3'b000);
        chk("reset_in_ready", in_ready, 1'b1);
        step();

        // 1: single addi
        out_ready = 3'b111;
        push(32'h00A00093, 32'h100);
        @(negedge clk);
        chk("t1_out_valid", out_valid, 3'b001);
        chk("t1_opcode", out_opcode, 7'b0010011);
        chk("t1_spec", out_spec, 1'b1);
        chk("t1_pc", out_pc, 32'h100);
        step();
        @(negedge clk);
        chk("t1_dispatch_count", dispatch_count, 16'd1);
        step();

        // 2: backpressure with sw then jal
        out_ready = 3'b000;
        push(32'h00112023, 32'h104);
        push(32'h0000006F, 32'h108);
        @(negedge clk);
        chk("t2_in_ready_full", in_ready, 1'b0);
        chk("t2_out_valid_sw", out_valid, 3'b010);
        chk("t2_spec_sw", out_spec, 1'b0);
        step();
        out_ready = 3'b010;
        step();
        @(negedge clk);
        chk("t2_out_valid_jal", out_valid, 3'b100);
        chk("t2_spec_jal", out_spec, 1'b0);
        step();
        out_ready = 3'b111;
        repeat (2) step();

        // 3: streaming lui/beq/add across pointer wraps
        for (int i = 0; i < 24; i++) begin
            case (i % 3)
                0:       push(32'h12345037, 32'h200 + 32'(i * 4));
                1:       push(32'h00208463, 32'h200 + 32'(i * 4));
                default: push(32'h002081B3, 32'h200 + 32'(i * 4));
            endcase
        end
        repeat (2) step();
        @(negedge clk);
        chk("t3_dispatch_count", dispatch_count, 16'd27);
        step();

        // 4: flush a full FIFO with a concurrent push
        out_ready = 3'b000;
        push(32'h002081B3, 32'h300);
        push(32'h00A00093, 32'h304);
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'h12345037; in_pc = 32'h308;
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("t4_out_valid", out_valid, 3'b000);
        chk("t4_in_ready", in_ready, 1'b1);
        step();

        // 5: undecodable word followed by add
        out_ready = 3'b111;
        push(32'h00000000, 32'h400);
        push(32'h002081B3, 32'h404);
        @(negedge clk);
`ifdef DECODE_ILLEGAL_TRAP_EN
        chk("t5_trap_valid", trap_valid, 1'b1);
        chk("t5_trap_pc", trap_pc, 32'h400);
        chk("t5_in_ready", in_ready, 1'b0);
        step();
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
        @(negedge clk);
        chk("t5_after_ack_in_ready", in_ready, 1'b1);
        chk("t5_after_ack_out_valid", out_valid, 3'b000);
        chk("t5_drop_count", drop_count, 16'd1);
`else
        chk("t5_drop_count", drop_count, 16'd1);
        chk("t5_out_valid", out_valid, 3'b001);
        chk("t5_out_pc", out_pc, 32'h404);
`endif
        step();
        repeat (2) step();

        // 6: reset mid-stream with two entries queued
        out_ready = 3'b000;
        push(32'h002081B3, 32'h500);
        push(32'h00112023, 32'h504);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_out_valid", out_valid, 3'b000);
        chk("t6_dispatch_count", dispatch_count, 16'd0);
        chk("t6_drop_count", drop_count, 16'd0);
        chk("t6_in_ready", in_ready, 1'b1);
        step();

        // Randomized traffic against the reference model
        for (int i = 0; i < 4000; i++) begin
            r         = $urandom();
            in_valid  = ($urandom_range(0, 9) < 7);
            in_instr  = {r[31:7], OP_TAB[$urandom_range(0, 11)]};
            in_pc     = $urandom();
            out_ready = 3'($urandom_range(0, 7));
            flush     = ($urandom_range(0, 49) == 0);
            rst       = ($urandom_range(0, 499) == 0);
`ifdef DECODE_ILLEGAL_TRAP_EN
            trap_ack  = ($urandom_range(0, 4) == 0);
`endif
            step();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
